wb_stage: RTL and testbench
===========================

# wb_stage

MEM/WB pipeline stage of the MIPS core: registers the memory-stage result, aligns and sign-/zero-extends load data (including LWL/LWR merge), and drives the register-file write port directly (`wb_we`/`wb_waddr`/`wb_wdata` feed the regfile's `we`/`waddr`/`wdata`). It honours the pipeline stall vector and flush, inserting bubbles or holding state so the regfile never sees a spurious or duplicated architectural write.

## Interface
- `DATA_W`, 32, datapath width (only 32 supported)
- `ADDR_W`, 5, register address width
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low (`rst`=0 resets)
- `stall_mem`  in  1  MEM stage stalled this cycle
- `stall_wb`  in  1  WB stage stalled this cycle
- `flush`  in  1  discard the instruction entering WB
- `mem_wreg`  in  1  instruction writes a GPR
- `mem_wd`  in  ADDR_W  destination register
- `mem_wdata`  in  DATA_W  ALU/non-load result
- `mem_load`  in  1  instruction is a load
- `mem_ldop`  in  3  load type (package encoding)
- `mem_addr_lo`  in  2  effective address bits [1:0]
- `mem_rdata`  in  DATA_W  data-memory read word (big-endian)
- `mem_rt_old`  in  DATA_W  current rt value, for LWL/LWR merge
- `wb_we`  out  1  regfile write enable
- `wb_waddr`  out  ADDR_W  regfile write address
- `wb_wdata`  out  DATA_W  regfile write data
- `wb_adel`  out  1  misaligned-load exception flag for this WB slot

## Operation
- Next-state priority each rising edge: `flush` → bubble; else `stall_mem`&&!`stall_wb` → bubble; else `stall_wb` → hold all outputs; else load new.
- Bubble: `wb_we`=0, `wb_waddr`=0, `wb_wdata`=0, `wb_adel`=0.
- New value: non-load → `wb_wdata`=`mem_wdata`. Load → aligned data per `mem_ldop`:
  - LW(0): `mem_rdata`; LB(1)/LBU(2): byte at lane `addr_lo` (lane 0 = bits 31:24), sign/zero-extended.
  - LH(3)/LHU(4): halfword at `addr_lo[1]` (0 = bits 31:16), sign/zero-extended.
  - LWL(5): lo 0 `rdata`; 1 {rdata[23:0],rt[7:0]}; 2 {rdata[15:0],rt[15:0]}; 3 {rdata[7:0],rt[23:0]}.
  - LWR(6): lo 0 {rt[31:8],rdata[31:24]}; 1 {rt[31:16],rdata[31:16]}; 2 {rt[31:24],rdata[31:8]}; 3 `rdata`.
  - Reserved(7): write suppressed.
- Misaligned: LW with `addr_lo`≠0, LH/LHU with `addr_lo[0]`=1 → `wb_adel`=1, `wb_we`=0, data 0.
- `wb_we` = `mem_wreg` && `mem_wd`≠0 && no suppression; writes to $0 never leave this block.

## Timing
- Latency 1 cycle: inputs sampled on edge N appear on outputs after edge N, regfile commits at edge N+1.
- All outputs registered; no combinational input→output path.
- Reset (`rst`=0, asynchronous): all outputs 0 immediately, regardless of clock; reset mid-hold discards the held instruction. First load after deassertion on the next edge with `rst`=1.
- Hold keeps `wb_we` asserted for repeated cycles; regfile rewrites same value (idempotent), accepted.
- `flush` during `stall_wb` still bubbles (flush dominates).

## Structure
- Shared package/defines: `LDOP_*` encodings (LW..LWR, reserved), `DATA_W`/`ADDR_W` widths, zero-word constant.
- One combinational sub-module `load_align` (ldop, addr_lo, rdata, rt_old → data, misaligned); wb_stage holds the register and stall/flush control.

## Test plan
- Reset: drive nonzero inputs, pulse `rst`=0 between edges → all outputs 0 without a clock edge.
- LB sign-extend: load, ldop=1, addr_lo=2, rdata=0x1234_8678, wd=5 → next cycle we=1, waddr=5, wdata=0xFFFF_FF86; LBU same → 0x0000_0086.
- LWL/LWR merge: rdata=0xAABB_CCDD, rt=0x1122_3344, addr_lo=1 → LWL 0xBBCC_DD44; LWR 0x1122_AABB.
- Misaligned LH addr_lo=1, wd=7 → wb_adel=1, wb_we=0, wdata=0.
- Stall: stall_mem=1, stall_wb=0 → bubble (we=0); stall_mem=stall_wb=1 for 3 cycles → outputs held unchanged; release → next instruction appears 1 cycle later.
- Flush + $0: flush=1 with valid write → we=0; non-load mem_wreg=1, wd=0 → we=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared widths, load-type encodings and writeback payload for the MEM/WB stage.
package wb_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned LDOP_W = 3;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [LDOP_W-1:0] {
    LDOP_LW   = 3'd0,
    LDOP_LB   = 3'd1,
    LDOP_LBU  = 3'd2,
    LDOP_LH   = 3'd3,
    LDOP_LHU  = 3'd4,
    LDOP_LWL  = 3'd5,
    LDOP_LWR  = 3'd6,
    LDOP_RSVD = 3'd7
  } ldop_e;

  // One writeback slot as seen by the register file.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              adel;
  } wb_slot_t;

  localparam wb_slot_t WB_BUBBLE = '0;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB bus: pipeline control, memory-stage result and regfile write port.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic              stall_mem;
  logic              stall_wb;
  logic              flush;
  logic              mem_wreg;
  logic [ADDR_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_load;
  logic [LDOP_W-1:0] mem_ldop;
  logic [1:0]        mem_addr_lo;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_rt_old;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_adel;

  modport master (
    output stall_mem, stall_wb, flush, mem_wreg, mem_wd, mem_wdata,
           mem_load, mem_ldop, mem_addr_lo, mem_rdata, mem_rt_old,
    input  wb_we, wb_waddr, wb_wdata, wb_adel
  );

  modport slave (
    input  stall_mem, stall_wb, flush, mem_wreg, mem_wd, mem_wdata,
           mem_load, mem_ldop, mem_addr_lo, mem_rdata, mem_rt_old,
    output wb_we, wb_waddr, wb_wdata, wb_adel
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// Big-endian load alignment, extension and LWL/LWR merge (purely combinational).
module load_align
  import wb_stage_pkg::*;
(
  input  ldop_e             i_ldop,
  input  logic [1:0]        i_addr_lo,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [DATA_W-1:0] i_rt_old,
  output logic [DATA_W-1:0] o_data_c,
  output logic              o_misaligned_c,
  output logic              o_reserved_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte lane 0 is the most significant byte.
  always_comb begin
    w_byte = i_rdata[31:24];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[31:24];
      2'd1:    w_byte = i_rdata[23:16];
      2'd2:    w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];

  // Select and extend the loaded value; misaligned/reserved leave data at zero.
  always_comb begin
    o_data_c       = ZERO_WORD;
    o_misaligned_c = 1'b0;
    o_reserved_c   = 1'b0;
    case (i_ldop)
      LDOP_LW: begin
        if (i_addr_lo != 2'd0) o_misaligned_c = 1'b1;
        else                   o_data_c = i_rdata;
      end
      LDOP_LB:  o_data_c = {{24{w_byte[7]}}, w_byte};
      LDOP_LBU: o_data_c = {24'h0, w_byte};
      LDOP_LH: begin
        if (i_addr_lo[0]) o_misaligned_c = 1'b1;
        else              o_data_c = {{16{w_half[15]}}, w_half};
      end
      LDOP_LHU: begin
        if (i_addr_lo[0]) o_misaligned_c = 1'b1;
        else              o_data_c = {16'h0, w_half};
      end
      LDOP_LWL: begin
        case (i_addr_lo)
          2'd0:    o_data_c = i_rdata;
          2'd1:    o_data_c = {i_rdata[23:0], i_rt_old[7:0]};
          2'd2:    o_data_c = {i_rdata[15:0], i_rt_old[15:0]};
          default: o_data_c = {i_rdata[7:0],  i_rt_old[23:0]};
        endcase
      end
      LDOP_LWR: begin
        case (i_addr_lo)
          2'd0:    o_data_c = {i_rt_old[31:8],  i_rdata[31:24]};
          2'd1:    o_data_c = {i_rt_old[31:16], i_rdata[31:16]};
          2'd2:    o_data_c = {i_rt_old[31:24], i_rdata[31:8]};
          default: o_data_c = i_rdata;
        endcase
      end
      default: o_reserved_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register driving the regfile write port, with stall/flush control.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  wb_slot_t          r_wb;
  wb_slot_t          w_new;
  wb_slot_t          w_next;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_misaligned;
  logic              w_reserved;
  logic              w_supp;

  load_align u_load_align (
    .i_ldop         (ldop_e'(bus.mem_ldop)),
    .i_addr_lo      (bus.mem_addr_lo),
    .i_rdata        (bus.mem_rdata),
    .i_rt_old       (bus.mem_rt_old),
    .o_data_c       (w_ld_data),
    .o_misaligned_c (w_misaligned),
    .o_reserved_c   (w_reserved)
  );

  // Build the incoming slot; $0 and suppressed loads never raise the write enable.
  always_comb begin
    w_new       = WB_BUBBLE;
    w_supp      = bus.mem_load && (w_misaligned || w_reserved);
    w_new.waddr = bus.mem_wd;
    w_new.we    = bus.mem_wreg && (bus.mem_wd != ADDR_W'(0)) && !w_supp;
    w_new.adel  = bus.mem_load && w_misaligned;
    if (!bus.mem_load) w_new.wdata = bus.mem_wdata;
    else if (w_supp)   w_new.wdata = ZERO_WORD;
    else               w_new.wdata = w_ld_data;
  end

  // Flush beats everything; a MEM-only stall empties WB; a WB stall holds.
  always_comb begin
    w_next = r_wb;
    if (bus.flush)                           w_next = WB_BUBBLE;
    else if (bus.stall_mem && !bus.stall_wb) w_next = WB_BUBBLE;
    else if (bus.stall_wb)                   w_next = r_wb;
    else                                     w_next = w_new;
  end

  // Writeback slot register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wb <= WB_BUBBLE;
    else      r_wb <= w_next;
  end

  assign bus.wb_we    = r_wb.we;
  assign bus.wb_waddr = r_wb.waddr;
  assign bus.wb_wdata = r_wb.wdata;
  assign bus.wb_adel  = r_wb.adel;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  wb_stage_if bus_if ();

  wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached=1 required=0");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic we, input logic [4:0] waddr,
                         input logic [31:0] wdata, input logic adel);
    chk({tag, ".we"},    32'(bus_if.wb_we),    32'(we));
    chk({tag, ".waddr"}, 32'(bus_if.wb_waddr), 32'(waddr));
    chk({tag, ".wdata"}, bus_if.wb_wdata,      wdata);
    chk({tag, ".adel"},  32'(bus_if.wb_adel),  32'(adel));
  endtask

  task automatic set_ld(input logic [2:0] op, input logic [1:0] lo, input logic [4:0] wd,
                        input logic [31:0] rdata, input logic [31:0] rt);
    bus_if.mem_load    = 1'b1;
    bus_if.mem_wreg    = 1'b1;
    bus_if.mem_ldop    = op;
    bus_if.mem_addr_lo = lo;
    bus_if.mem_wd      = wd;
    bus_if.mem_rdata   = rdata;
    bus_if.mem_rt_old  = rt;
    bus_if.mem_wdata   = 32'hCAFE_0000;
  endtask

  task automatic set_alu(input logic wreg, input logic [4:0] wd, input logic [31:0] d);
    bus_if.mem_load  = 1'b0;
    bus_if.mem_wreg  = wreg;
    bus_if.mem_wd    = wd;
    bus_if.mem_wdata = d;
    bus_if.mem_ldop  = 3'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.stall_mem   = 1'b0;
    bus_if.stall_wb    = 1'b0;
    bus_if.flush       = 1'b0;
    bus_if.mem_wreg    = 1'b0;
    bus_if.mem_wd      = '0;
    bus_if.mem_wdata   = '0;
    bus_if.mem_load    = 1'b0;
    bus_if.mem_ldop    = '0;
    bus_if.mem_addr_lo = '0;
    bus_if.mem_rdata   = '0;
    bus_if.mem_rt_old  = '0;

    // Power-on reset before any clock edge.
    #1 rst = 1'b0;
    #1 chk_all("reset0", 1'b0, 5'd0, 32'h0, 1'b0);
    #1 rst = 1'b1;

    // LB sign-extend, lane 2.
    set_ld(3'd1, 2'd2, 5'd5, 32'h1234_8678, 32'h0);
    step();
    chk_all("lb", 1'b1, 5'd5, 32'hFFFF_FF86, 1'b0);

    // LBU same address.
    set_ld(3'd2, 2'd2, 5'd5, 32'h1234_8678, 32'h0);
    step();
    chk_all("lbu", 1'b1, 5'd5, 32'h0000_0086, 1'b0);

    // Asynchronous reset pulse between edges.
    #2 rst = 1'b0;
    #1 chk_all("areset", 1'b0, 5'd0, 32'h0, 1'b0);
    #1 rst = 1'b1;
    step();
    chk_all("post_rst", 1'b1, 5'd5, 32'h0000_0086, 1'b0);

    // LB lane 0 and LH/LHU lower half.
    set_ld(3'd1, 2'd0, 5'd6, 32'h7F00_0000, 32'h0);
    step();
    chk_all("lb_lane0", 1'b1, 5'd6, 32'h0000_007F, 1'b0);
    set_ld(3'd3, 2'd2, 5'd6, 32'h1234_8678, 32'h0);
    step();
    chk_all("lh", 1'b1, 5'd6, 32'hFFFF_8678, 1'b0);
    set_ld(3'd4, 2'd2, 5'd6, 32'h1234_8678, 32'h0);
    step();
    chk_all("lhu", 1'b1, 5'd6, 32'h0000_8678, 1'b0);
    set_ld(3'd0, 2'd0, 5'd8, 32'h8765_4321, 32'h0);
    step();
    chk_all("lw", 1'b1, 5'd8, 32'h8765_4321, 1'b0);

    // LWL/LWR merges.
    set_ld(3'd5, 2'd1, 5'd4, 32'hAABB_CCDD, 32'h1122_3344);
    step();
    chk_all("lwl1", 1'b1, 5'd4, 32'hBBCC_DD44, 1'b0);
    set_ld(3'd6, 2'd1, 5'd4, 32'hAABB_CCDD, 32'h1122_3344);
    step();
    chk_all("lwr1", 1'b1, 5'd4, 32'h1122_AABB, 1'b0);
    set_ld(3'd5, 2'd3, 5'd4, 32'hAABB_CCDD, 32'h1122_3344);
    step();
    chk_all("lwl3", 1'b1, 5'd4, 32'hDD22_3344, 1'b0);
    set_ld(3'd6, 2'd0, 5'd4, 32'hAABB_CCDD, 32'h1122_3344);
    step();
    chk_all("lwr0", 1'b1, 5'd4, 32'h1122_33AA, 1'b0);

    // Misaligned loads and reserved op.
    set_ld(3'd3, 2'd1, 5'd7, 32'h1234_8678, 32'h0);
    step();
    chk("lh_mis.adel", 32'(bus_if.wb_adel), 32'd1);
    chk("lh_mis.we", 32'(bus_if.wb_we), 32'd0);
    chk("lh_mis.wdata", bus_if.wb_wdata, 32'h0);
    set_ld(3'd0, 2'd2, 5'd7, 32'h1234_8678, 32'h0);
    step();
    chk("lw_mis.adel", 32'(bus_if.wb_adel), 32'd1);
    chk("lw_mis.we", 32'(bus_if.wb_we), 32'd0);
    set_ld(3'd7, 2'd0, 5'd7, 32'h1234_8678, 32'h0);
    step();
    chk("rsvd.we", 32'(bus_if.wb_we), 32'd0);
    chk("rsvd.adel", 32'(bus_if.wb_adel), 32'd0);

    // Non-load result.
    set_alu(1'b1, 5'd9, 32'hDEAD_BEEF);
    step();
    chk_all("alu", 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0);

    // MEM-only stall inserts a bubble.
    bus_if.stall_mem = 1'b1;
    step();
    chk_all("stall_mem", 1'b0, 5'd0, 32'h0, 1'b0);
    bus_if.stall_mem = 1'b0;
    step();
    chk_all("reload", 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0);

    // Both stalled for three cycles: outputs held while inputs change.
    bus_if.stall_mem = 1'b1;
    bus_if.stall_wb  = 1'b1;
    set_alu(1'b1, 5'd3, 32'h0000_0055);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("hold", 1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0);
    end
    bus_if.stall_mem = 1'b0;
    bus_if.stall_wb  = 1'b0;
    step();
    chk_all("release", 1'b1, 5'd3, 32'h0000_0055, 1'b0);

    // Flush during a WB stall still bubbles.
    bus_if.stall_wb = 1'b1;
    bus_if.flush    = 1'b1;
    step();
    chk_all("flush_stall", 1'b0, 5'd0, 32'h0, 1'b0);
    bus_if.stall_wb = 1'b0;

    // Flush with a valid write.
    set_alu(1'b1, 5'd12, 32'h1111_2222);
    step();
    chk_all("flush", 1'b0, 5'd0, 32'h0, 1'b0);
    bus_if.flush = 1'b0;

    // Write to $0 is dropped.
    set_alu(1'b1, 5'd0, 32'h3333_4444);
    step();
    chk("r0.we", 32'(bus_if.wb_we), 32'd0);

    // mem_wreg low: no write.
    set_alu(1'b0, 5'd10, 32'h5555_6666);
    step();
    chk("nowreg.we", 32'(bus_if.wb_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
